// File: rtl/seg_display_mux_if.sv
// Signal bundle between a display driver client and seg_display_mux.
// The duty input exists only when DISP_MUX_DIM_EN is defined.
interface seg_display_mux_if;
  logic       clk_div;
  logic [3:0] digit0;
  logic [3:0] digit1;
`ifdef DISP_MUX_DIM_EN
  logic [3:0] duty;
`endif
  logic [6:0] seg;
  logic [1:0] anode_en;
  logic [1:0] fsm_state;

  modport master (
    output clk_div,
    output digit0,
    output digit1,
`ifdef DISP_MUX_DIM_EN
    output duty,
`endif
    input  seg,
    input  anode_en,
    input  fsm_state
  );

  modport slave (
    input  clk_div,
    input  digit0,
    input  digit1,
`ifdef DISP_MUX_DIM_EN
    input  duty,
`endif
    output seg,
    output anode_en,
    output fsm_state
  );
endinterface

// File: rtl/seg_display_mux.sv
// Two-digit common-anode seven-segment multiplexer with blanking between hand-offs.
// Optional anode PWM dimming is enabled by defining DISP_MUX_DIM_EN.
module seg_display_mux #(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic            clk,
  input  logic            reset,
  seg_display_mux_if.slave bus
);

  localparam logic [1:0] SHOW0  = 2'd0;
  localparam logic [1:0] BLANK0 = 2'd1;
  localparam logic [1:0] SHOW1  = 2'd2;
  localparam logic [1:0] BLANK1 = 2'd3;

  // With zero blank cycles the blank state (only reachable from reset) exits on its first edge.
  localparam logic [7:0] BLANK_LAST = (BLANK_CYCLES == 0) ? 8'd0 : 8'(BLANK_CYCLES - 1);

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [1:0] ANODE_OFF = 2'b11;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic       clk_div_q;
  logic       tick;
  logic [1:0] state;
  logic [1:0] state_n;
  logic [7:0] blank_cnt;
  logic [7:0] blank_cnt_n;
  logic [3:0] hold;
  logic [3:0] hold_n;
  logic [6:0] seg_q;
  logic [6:0] seg_n;
  logic [1:0] anode_q;
  logic [1:0] anode_n;
  logic       lit;

  assign tick = bus.clk_div & ~clk_div_q;

`ifdef DISP_MUX_DIM_EN
  logic [3:0] pwm_cnt;
  logic [3:0] pwm_n;

  // Gate on the counter value that will be current while this anode value is displayed.
  assign pwm_n = pwm_cnt + 4'd1;
  assign lit   = (pwm_n < bus.duty);

  always_ff @(posedge clk) begin
    if (!reset) pwm_cnt <= 4'd0;
    else        pwm_cnt <= pwm_n;
  end
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    state_n     = state;
    blank_cnt_n = blank_cnt;
    hold_n      = hold;
    case (state)
      SHOW0: begin
        if (tick) begin
          if (BLANK_CYCLES == 0) begin
            state_n = SHOW1;
            hold_n  = bus.digit1;
          end else begin
            state_n     = BLANK0;
            blank_cnt_n = 8'd0;
          end
        end
      end
      BLANK0: begin
        if (blank_cnt == BLANK_LAST) begin
          state_n     = SHOW1;
          hold_n      = bus.digit1;
          blank_cnt_n = 8'd0;
        end else begin
          blank_cnt_n = blank_cnt + 8'd1;
        end
      end
      SHOW1: begin
        if (tick) begin
          if (BLANK_CYCLES == 0) begin
            state_n = SHOW0;
            hold_n  = bus.digit0;
          end else begin
            state_n     = BLANK1;
            blank_cnt_n = 8'd0;
          end
        end
      end
      default: begin
        if (blank_cnt == BLANK_LAST) begin
          state_n     = SHOW0;
          hold_n      = bus.digit0;
          blank_cnt_n = 8'd0;
        end else begin
          blank_cnt_n = blank_cnt + 8'd1;
        end
      end
    endcase
  end

  // Outputs are computed from the next state so the registered pins line up with the state register.
  always_comb begin
    seg_n   = SEG_OFF;
    anode_n = ANODE_OFF;
    case (state_n)
      SHOW0: begin
        seg_n   = decode(hold_n);
        anode_n = lit ? 2'b10 : ANODE_OFF;
      end
      SHOW1: begin
        seg_n   = decode(hold_n);
        anode_n = lit ? 2'b01 : ANODE_OFF;
      end
      default: begin
        seg_n   = SEG_OFF;
        anode_n = ANODE_OFF;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_div_q <= 1'b1;
      state     <= BLANK1;
      blank_cnt <= 8'd0;
      hold      <= 4'd0;
      seg_q     <= SEG_OFF;
      anode_q   <= ANODE_OFF;
    end else begin
      clk_div_q <= bus.clk_div;
      state     <= state_n;
      blank_cnt <= blank_cnt_n;
      hold      <= hold_n;
      seg_q     <= seg_n;
      anode_q   <= anode_n;
    end
  end

  assign bus.seg       = seg_q;
  assign bus.anode_en  = anode_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: one instance with 4 blank cycles, one with none.
// Builds with or without DISP_MUX_DIM_EN.
module tb_seg_display_mux;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seg_display_mux_if ia ();
  seg_display_mux_if ib ();

  seg_display_mux #(.BLANK_CYCLES(4)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
  seg_display_mux #(.BLANK_CYCLES(0)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] digit;
    logic [6:0] seg;
  } vec_t;
  vec_t tbl[16];

  localparam logic [6:0] OFF = 7'h7F;

`ifdef DISP_MUX_DIM_EN
  logic [3:0] tb_pwm = 4'd0;
  always @(posedge clk) tb_pwm <= reset ? tb_pwm + 4'd1 : 4'd0;
`endif

  function automatic logic [1:0] exp_an(input logic [1:0] ea, input logic [3:0] duty);
`ifdef DISP_MUX_DIM_EN
    if (ea != 2'b11 && !(tb_pwm < duty)) return 2'b11;
`endif
    return ea;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [6:0] s, input logic [1:0] a,
                     input logic [6:0] es, input logic [1:0] ea);
    total++;
    if (s !== es || a !== ea) begin
      bad++;
      $display("FAIL %s: seg=%b anode_en=%b expected seg=%b anode_en=%b", name, s, a, es, ea);
    end
  endtask

  task automatic chk_a(input string name, input logic [6:0] es, input logic [1:0] ea);
    logic [3:0] d;
`ifdef DISP_MUX_DIM_EN
    d = ia.duty;
`else
    d = 4'd0;
`endif
    chk(name, ia.seg, ia.anode_en, es, exp_an(ea, d));
  endtask

  task automatic chk_b(input string name, input logic [6:0] es, input logic [1:0] ea);
    logic [3:0] d;
`ifdef DISP_MUX_DIM_EN
    d = ib.duty;
`else
    d = 4'd0;
`endif
    chk(name, ib.seg, ib.anode_en, es, exp_an(ea, d));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      total++;
      if (ia.anode_en === 2'b00 || ib.anode_en === 2'b00) begin
        bad++;
        $display("FAIL anode_never_00: a=%b b=%b expected neither 00", ia.anode_en, ib.anode_en);
      end
    end
  end

  initial begin
    int on;
    tbl[0]  = '{4'h0, 7'b1000000}; tbl[1]  = '{4'h1, 7'b1111001};
    tbl[2]  = '{4'h2, 7'b0100100}; tbl[3]  = '{4'h3, 7'b0110000};
    tbl[4]  = '{4'h4, 7'b0011001}; tbl[5]  = '{4'h5, 7'b0010010};
    tbl[6]  = '{4'h6, 7'b0000010}; tbl[7]  = '{4'h7, 7'b1111000};
    tbl[8]  = '{4'h8, 7'b0000000}; tbl[9]  = '{4'h9, 7'b0010000};
    tbl[10] = '{4'hA, 7'b0001000}; tbl[11] = '{4'hB, 7'b0000011};
    tbl[12] = '{4'hC, 7'b1000110}; tbl[13] = '{4'hD, 7'b0100001};
    tbl[14] = '{4'hE, 7'b0000110}; tbl[15] = '{4'hF, 7'b0001110};

    ia.clk_div = 1'b0; ia.digit0 = 4'h3; ia.digit1 = 4'hA;
    ib.clk_div = 1'b0; ib.digit0 = 4'h5; ib.digit1 = 4'h0;
`ifdef DISP_MUX_DIM_EN
    ia.duty = 4'd4;
    ib.duty = 4'd15;
`endif

    // Reset and release
    reset = 1'b0;
    cyc(1);
    chk_a("reset_a", OFF, 2'b11);
    chk_b("reset_b", OFF, 2'b11);
    total++;
    if (ia.fsm_state !== 2'd3) begin
      bad++;
      $display("FAIL reset_state: state=%0d expected 3", ia.fsm_state);
    end
    cyc(1);
    reset = 1'b1;
    cyc(1);
    chk_a("release_blank_0", OFF, 2'b11);
    chk_b("b_show0_no_blank", 7'b0010010, 2'b10);
    for (int i = 1; i < 3; i++) begin
      cyc(1);
      chk_a($sformatf("release_blank_%0d", i), OFF, 2'b11);
    end
    cyc(1);
    chk_a("show0_entry", 7'b0110000, 2'b10);
    cyc(5);
    chk_a("show0_hold", 7'b0110000, 2'b10);

    // Digit change mid-SHOW0 is not visible
    ia.digit0 = 4'h8;
    cyc(2);
    chk_a("digit_change_mid_show0", 7'b0110000, 2'b10);

    // Tick to BLANK0, with a dropped tick inside the blank window
    ia.clk_div = 1'b1;
    cyc(1);
    chk_a("tick_to_blank0", OFF, 2'b11);
    ia.clk_div = 1'b0;
    cyc(1);
    chk_a("blank0_1", OFF, 2'b11);
    ia.clk_div = 1'b1;
    cyc(1);
    chk_a("tick_in_blank0", OFF, 2'b11);
    cyc(1);
    chk_a("blank0_3", OFF, 2'b11);
    cyc(1);
    chk_a("show1_entry", 7'b0001000, 2'b01);
    cyc(6);
    chk_a("dropped_tick_no_effect", 7'b0001000, 2'b01);

    // Back to SHOW0 which picks up the new digit0
    ia.clk_div = 1'b0;
    cyc(1);
    chk_a("show1_clk_div_low", 7'b0001000, 2'b01);
    ia.clk_div = 1'b1;
    cyc(1);
    chk_a("tick_to_blank1", OFF, 2'b11);
    for (int i = 1; i < 4; i++) begin
      cyc(1);
      chk_a($sformatf("blank1_%0d", i), OFF, 2'b11);
    end
    cyc(1);
    chk_a("show0_reentry_new_digit", 7'b0000000, 2'b10);

    // Reset in the middle of SHOW1 with clk_div held high
    ia.clk_div = 1'b0;
    cyc(1);
    ia.clk_div = 1'b1;
    cyc(1);
    chk_a("tick_to_blank0_again", OFF, 2'b11);
    cyc(4);
    chk_a("show1_again", 7'b0001000, 2'b01);
    reset = 1'b0;
    cyc(1);
    chk_a("reset_mid_show1", OFF, 2'b11);
    chk_b("reset_mid_b", OFF, 2'b11);
    cyc(1);
    reset = 1'b1;
    for (int i = 1; i < 4; i++) begin
      cyc(1);
      chk_a($sformatf("rerelease_blank_%0d", i), OFF, 2'b11);
    end
    cyc(1);
    chk_a("show0_after_rerelease", 7'b0000000, 2'b10);
    cyc(6);
    chk_a("held_clk_div_no_tick", 7'b0000000, 2'b10);

    // Zero-blank instance: decode sweep, swapping on each clk_div rise
    chk_b("b_show0_before_sweep", 7'b0010010, 2'b10);
    for (int i = 0; i < 16; i++) begin
      ib.digit1 = tbl[i].digit;
      ib.clk_div = 1'b1;
      cyc(1);
      chk_b($sformatf("decode_disp1_%0d", i), tbl[i].seg, 2'b01);
      ib.clk_div = 1'b0;
      ib.digit0 = tbl[15-i].digit;
      cyc(1);
      ib.clk_div = 1'b1;
      cyc(1);
      chk_b($sformatf("decode_disp0_%0d", 15-i), tbl[15-i].seg, 2'b10);
      ib.clk_div = 1'b0;
      cyc(1);
    end

    // Anode on-time across 16 cycles of a steady SHOW0
    on = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1);
      if (ia.anode_en === 2'b10) on++;
    end
    total++;
`ifdef DISP_MUX_DIM_EN
    if (on != 4) begin
      bad++;
      $display("FAIL anode_on_time: on=%0d expected 4", on);
    end
`else
    if (on != 16) begin
      bad++;
      $display("FAIL anode_on_time: on=%0d expected 16", on);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_display_mux.md
Name: seg_display_mux

Overview:
- Sits directly downstream of the clock divider and consumes its divided clock output, clk_div.
- Time-multiplexes two 4-bit hex values onto one shared set of seven-segment lines that drives two common-anode displays.
- Each clk_div rising edge hands the segment bus to the other display.
- A dead-time (blank) gap between hand-offs prevents ghosting.

Parameters:
BLANK_CYCLES, 4, clk cycles of dead time between displays; legal range 0..255; 0 means no blank state.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset asserted)
clk_div  input  1  divided clock from the divider; treated as a level, rising edges detected internally
digit0  input  4  hex value for display 0
digit1  input  4  hex value for display 1
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
anode_en  output  2  display enables [1]=disp1, [0]=disp0, active-low

Behaviour:
- Edge detection
  - clk_div_q registers clk_div every cycle; reset value 1, which suppresses a spurious edge at reset release.
  - tick = clk_div & ~clk_div_q.
  - The state update occurs on the same posedge at which tick is sampled high, so there is a one-edge latency from a clk_div rise to an output change.
- States: SHOW0, BLANK0, SHOW1, BLANK1.
- Reset, whenever reset==0 at a posedge:
  - state<=BLANK1, blank_cnt<=0.
  - seg=7'h7F, anode_en=2'b11; these take effect on that edge, including when reset hits mid-operation.
- SHOW0
  - anode_en=2'b10; seg=decode(latched digit).
  - On tick: go to BLANK0 with blank_cnt<=0.
  - If BLANK_CYCLES==0, go directly to SHOW1 instead.
- BLANK0
  - anode_en=2'b11, seg=7'h7F.
  - blank_cnt increments each cycle.
  - When blank_cnt==BLANK_CYCLES-1, go to SHOW1 on the next edge, so exactly BLANK_CYCLES cycles are blank.
- SHOW1 and BLANK1 mirror SHOW0 and BLANK0 with anode_en=2'b01, then back to SHOW0.
- After reset release, BLANK1 runs its full BLANK_CYCLES count, then enters SHOW0; no tick is needed.
- A tick arriving during BLANK0 or BLANK1 is dropped, never queued.
- Digit latching
  - On the edge entering SHOWn, digitn is captured into a 4-bit hold register.
  - seg shows only the held value for the whole SHOW phase; digit input changes mid-phase have no effect until the next entry.
- Decoder (active-low, all 16 codes)
  - 0=7'b1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Outputs are registered: seg and anode_en come from flops, with no combinational path from inputs.
- anode_en is never 2'b00, under any input sequence.

Optional Feature:
Macro DISP_MUX_DIM_EN
- Defined:
  - Adds input port duty [3:0].
  - A free-running 4-bit pwm_cnt (reset 0) increments every cycle.
  - In SHOWn, the active anode is asserted only while pwm_cnt < duty; otherwise anode_en=2'b11.
  - duty=0 gives dark; duty=15 gives 15/16 on-time.
  - seg is unaffected; the state machine and blanking are unchanged.
- Undefined: no duty port; the anode is asserted for the entire SHOW phase.

Test Plan:
- Reset, then release with BLANK_CYCLES=4, digit0=4'h3, digit1=4'hA, clk_div=0 -> 4 cycles of seg=7'h7F / anode_en=2'b11, then seg=7'b0110000 with anode_en=2'b10.
- Raise clk_div -> on that edge: BLANK0 for 4 cycles; then seg=7'b0001000, anode_en=2'b01. A second clk_div rise returns to SHOW0 with 7'b0110000.
- Pulse clk_div high during BLANK0 -> the edge is ignored; SHOW1 then persists until the next clk_div rise after BLANK0 ends.
- Change digit0 from 3 to 8 mid-SHOW0 -> seg stays 7'b0110000 until the next SHOW0 entry, then reads 7'b0000000.
- Assert reset mid-SHOW1 -> the next edge gives seg=7'h7F, anode_en=2'b11. Holding clk_div=1 through reset release creates no tick.
- BLANK_CYCLES=0 -> each clk_div rise swaps 2'b10 and 2'b01 on the same edge with no all-off cycle. Sweep all 16 digit codes against the decode table. DISP_MUX_DIM_EN with duty=4 -> the anode is active 4 of every 16 cycles during SHOW.
